xor_share_arbiter: RTL and testbench
====================================

# xor_share_arbiter

Round-robin arbiter that shares one WIDTH-bit bitwise-XOR datapath between four requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle and registers the XOR result together with the winner's ID on a single output port with backpressure. It sits between the requester front-ends and the shared XOR node array.

## Interface
- WIDTH, 8, operand and result width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  4  per-requester operand-valid; bit i = requester i
- req_a  input  4*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  input  4*WIDTH  operand B, same packing as req_a
- req_ready  output  4  one-hot grant; bit i high = requester i's operands are accepted this cycle
- out_valid  output  1  result register holds a valid result
- out_data  output  WIDTH  registered req_a ^ req_b of the granted requester
- out_id  output  2  index of the requester that produced out_data
- out_ready  input  1  consumer accepts the result this cycle
- out_parity  output  1  XOR-reduction of out_data; present only with XOR_ARB_PARITY_EN

## Operation
- Slot free condition: slot_free = !out_valid || out_ready.
- Arbitration:
  - Combinational, over requesters with req_valid set.
  - A 2-bit priority pointer ptr names the highest-priority requester.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- req_ready: req_ready[i] = slot_free && (i is the first valid requester in search order). It is at most one-hot and is 0 when no request is valid.
- Acceptance: a transfer happens when req_valid[i] && req_ready[i]. On the next clk edge:
  - out_data <= req_a[i] ^ req_b[i]
  - out_id <= i
  - out_valid <= 1
  - ptr <= i+1 mod 4, so the winner drops to lowest priority.
- No grant with slot free: out_valid <= 0 and ptr is unchanged. out_data and out_id keep their last values.
- No grant with slot not free (out_valid && !out_ready): out_valid, out_data and out_id hold.
- Requester obligations: hold req_a and req_b stable while req_valid && !req_ready. Deasserting req_valid before acceptance is permitted; that request is simply dropped.
- Pointer states P0..P3 (ptr value):
  - Transition is Pk -> P(i+1) on a grant to requester i.
  - Otherwise Pk stays Pk.
- XOR arithmetic: purely bitwise over WIDTH bits, with no carries and no width growth.
- Reset (rst_n low, takes effect immediately, asynchronously): out_valid=0, out_data=0, out_id=0, ptr=0, req_ready=0.
  - A result pending at reset is discarded.
  - The first grant after reset favours requester 0.

## Timing
- Latency: 1 cycle from acceptance edge to out_valid.
- Throughput: 1 result per cycle while out_ready=1 and any request is valid.
- Simultaneous events: when out_valid && out_ready and a request is valid in the same cycle, the new result replaces the old at the edge with no bubble.
- Backpressure: req_ready is combinational from out_valid, out_ready, req_valid and ptr. There is no combinational path from req_a/req_b to any output.
- Fairness: with all 4 requesters continuously valid and out_ready=1, grants rotate 0,1,2,3,0,... and no requester waits more than 3 accepted transfers.
- out_ready low for N cycles: the result holds N cycles and all req_ready stay 0.

## Configuration
- XOR_ARB_PARITY_EN defined:
  - Adds the out_parity port.
  - out_parity is a register loaded with ^(req_a[i]^req_b[i]) alongside out_data, and held or reset identically (reset value 0).
- XOR_ARB_PARITY_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset mid-transfer:
  - Stimulus: load a result, hold out_ready=0, assert rst_n=0 asynchronously between edges.
  - Required: out_valid, out_data and out_id go to 0 immediately.
  - Required: after release, requesters 0 and 2 both valid grant 0 first.
- Single requester:
  - Stimulus: req_valid=4'b0100, a2=8'hA5, b2=8'h3C, out_ready=1.
  - Required: req_ready=4'b0100.
  - Required next cycle: out_valid=1, out_data=8'h99, out_id=2.
  - Required with XOR_ARB_PARITY_EN: out_parity=0.
- Round robin:
  - Stimulus: req_valid=4'b1111 for 8 cycles, out_ready=1, a_i=i, b_i=8'hF0.
  - Required: out_id sequence 0,1,2,3,0,1,2,3.
  - Required: out_data sequence F0,F1,F2,F3,F0,F1,F2,F3.
- Backpressure:
  - Stimulus: with out_valid=1, hold out_ready=0 for 3 cycles while req_valid=4'b0011.
  - Required: req_ready=0 and out_data/out_id stable for those 3 cycles.
  - Required: when out_ready rises, the next result appears one edge later with no lost or duplicated transfer.
- Pointer skip:
  - Stimulus: ptr=1 (after a grant to 0), req_valid=4'b1001.
  - Required: grant 3, then ptr=0, so a persisting req 0 wins next.
- Idle drain:
  - Stimulus: a result with out_ready=1 and req_valid=0.
  - Required: out_valid drops to 0 the next cycle, with out_data/out_id unchanged and ptr unchanged.

Source files
------------

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit XOR datapath among four requesters; 1-cycle registered result.
// Backpressure: req_ready is zero unless the result slot is empty or being drained this cycle.
// Optional out_parity register enabled by defining XOR_ARB_PARITY_EN.
module xor_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_a,
    input  logic [4*WIDTH-1:0] req_b,
    output logic [3:0]         req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_id,
`ifdef XOR_ARB_PARITY_EN
    output logic               out_parity,
`endif
    input  logic               out_ready
);

    typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} ptr_t;

    ptr_t             ptr, ptr_nxt;
    logic             slot_free;
    logic             gnt_any;
    logic             accept;
    logic [1:0]       gnt_id;
    logic [1:0]       idx;
    logic [WIDTH-1:0] sel_a, sel_b, xor_res;

    assign slot_free = !out_valid || out_ready;
    assign accept    = slot_free && gnt_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= P0;
        else        ptr <= ptr_nxt;
    end

    // Walk the search order backwards so the earliest valid requester is the last to write.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = 2'(ptr);
        idx       = 2'd0;
        req_ready = 4'b0000;
        ptr_nxt   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = 2'(ptr) + 2'(k);
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (rst_n && accept) begin
            req_ready = 4'b0001 << gnt_id;
            ptr_nxt   = ptr_t'(gnt_id + 2'd1);
        end
    end

    assign sel_a   = req_a[int'(gnt_id)*WIDTH +: WIDTH];
    assign sel_b   = req_b[int'(gnt_id)*WIDTH +: WIDTH];
    assign xor_res = sel_a ^ sel_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 2'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= xor_res;
            out_id    <= gnt_id;
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

`ifdef XOR_ARB_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_parity <= 1'b0;
        else if (accept) out_parity <= ^xor_res;
    end
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Randomized and directed bench for xor_share_arbiter against a queue-free behavioural model.
module tb_xor_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
`ifdef XOR_ARB_PARITY_EN
    logic        out_parity;
`endif

    xor_share_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
`ifdef XOR_ARB_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] op_a [4];
    logic [7:0] op_b [4];

    // Reference state: result register contents and who has top priority.
    int         m_ptr;
    bit         m_vld;
    logic [7:0] m_data;
    int         m_id;
    bit         m_par;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_data = 8'h00; m_id = 0; m_par = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
        chk({tag, ".out_id"},    32'(out_id),    32'(m_id));
`ifdef XOR_ARB_PARITY_EN
        chk({tag, ".out_parity"}, 32'(out_parity), 32'(m_par));
`endif
    endtask

    // One clock: drive at negedge, check grant, clock it, check the registered result.
    task automatic step(input logic [3:0] v, input logic ordy, input string tag);
        int  gi;
        bit  free;
        logic [3:0] exp_rdy;
        @(negedge clk);
        req_valid = v;
        out_ready = ordy;
        req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
        req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
        free = !m_vld || ordy;
        gi = -1;
        if (free)
            for (int k = 0; k < 4; k++)
                if (gi < 0 && v[(m_ptr + k) % 4]) gi = (m_ptr + k) % 4;
        exp_rdy = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
        #1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (gi >= 0) begin
            m_vld  = 1;
            m_data = op_a[gi] ^ op_b[gi];
            m_id   = gi;
            m_par  = ^m_data;
            m_ptr  = (gi + 1) % 4;
        end else if (free) begin
            m_vld = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 4'b0; out_ready = 1'b0; req_a = '0; req_b = '0;
        model_reset();
        #12;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin with all requesters valid.
        for (int i = 0; i < 4; i++) begin op_a[i] = 8'(i); op_b[i] = 8'hF0; end
        for (int n = 0; n < 8; n++) begin
            step(4'b1111, 1'b1, "rr");
            chk("rr.id_seq",   32'(out_id),   32'(n % 4));
            chk("rr.data_seq", 32'(out_data), 32'(8'hF0 + 8'(n % 4)));
        end

        // Single requester 2.
        op_a[2] = 8'hA5; op_b[2] = 8'h3C;
        step(4'b0100, 1'b1, "single");
        chk("single.data", 32'(out_data), 32'h99);
        chk("single.id",   32'(out_id),   32'd2);
`ifdef XOR_ARB_PARITY_EN
        chk("single.parity", 32'(out_parity), 32'd0);
`endif

        // Pointer skip: grant 0 moves ptr to 1, then 3 beats 0, then 0 wins.
        step(4'b0001, 1'b1, "skip0");
        step(4'b1001, 1'b1, "skip1");
        chk("skip.grant3", 32'(out_id), 32'd3);
        step(4'b1001, 1'b1, "skip2");
        chk("skip.grant0", 32'(out_id), 32'd0);

        // Backpressure for three cycles, then release.
        for (int n = 0; n < 3; n++) begin
            op_a[0] = 8'($urandom); op_a[1] = 8'($urandom);
            step(4'b0011, 1'b0, "bp_hold");
        end
        step(4'b0011, 1'b1, "bp_release");
        chk("bp.release_id", 32'(out_id), 32'd1);

        // Idle drain.
        step(4'b0000, 1'b1, "drain");
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = 8'($urandom); op_b[i] = 8'($urandom);
            end
            step(4'($urandom), ($urandom_range(0, 3) != 0), "rand");
        end

        // Reset while a result is stalled.
        step(4'b0001, 1'b1, "rst_load");
        step(4'b0000, 1'b0, "rst_hold");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async.out_valid", 32'(out_valid), 32'd0);
        chk("rst_async.out_data",  32'(out_data),  32'd0);
        chk("rst_async.out_id",    32'(out_id),    32'd0);
        chk("rst_async.req_ready", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b1;
        op_a[0] = 8'h12; op_b[0] = 8'h34; op_a[2] = 8'h56; op_b[2] = 8'h78;
        step(4'b0101, 1'b1, "post_rst");
        chk("post_rst.id",   32'(out_id),   32'd0);
        chk("post_rst.data", 32'(out_data), 32'h26);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
